// File: rtl/dsm_cifb_if.sv
// Sample/strobe bundle between the sample source, the modulator and the level driver.
// The master drives samples and controls. The slave (the modulator) returns codes and status.
interface dsm_cifb_if #(
    parameter int IN_W = 11,
    parameter int Q_W  = 2
);
    logic                   en;
    logic                   dith_en;
    logic                   in_valid;
    logic signed [IN_W-1:0] vin;
    logic                   ovl_clr;
    logic                   out_valid;
    logic signed [Q_W-1:0]  out_code;
    logic                   ovl_flag;

    modport master (
        output en, dith_en, in_valid, vin, ovl_clr,
        input  out_valid, out_code, ovl_flag
    );

    modport slave (
        input  en, dith_en, in_valid, vin, ovl_clr,
        output out_valid, out_code, ovl_flag
    );
endinterface

// File: rtl/dsm_cifb_mod.sv
// Multi-bit delta-sigma modulator with a CIFB loop of ORDER integrators.
// The quantizer can add LFSR dither. Every integrator saturates instead of wrapping.
// A run of consecutive clamped codes counts as overload: the loop state is flushed
// and zero codes are sent for RECOVER_LEN samples before normal operation resumes.
module dsm_cifb_mod #(
    parameter int IN_W        = 11,
    parameter int ACC_W       = 17,
    parameter int ORDER       = 2,
    parameter int Q_W         = 2,
    parameter int GAIN_SHIFT  = 1,
    parameter int DITH_W      = 4,
    parameter int OVL_LIMIT   = 16,
    parameter int RECOVER_LEN = 8
) (
    input  logic      clock,
    input  logic      reset,
    dsm_cifb_if.slave bus
);
    // The quantizer step is 2^(IN_W-2). Sums carry three guard bits above ACC_W,
    // so the saturation function sees the true value.
    localparam int STEP_SH = IN_W - 2;
    localparam int LMAX    = (2 ** (Q_W - 1)) - 1;
    localparam int EXT_W   = ACC_W + 3;
    localparam int OVL_W   = $clog2(OVL_LIMIT + 1);
    localparam int REC_W   = $clog2(RECOVER_LEN + 1);

    localparam logic [15:0]             LFSR_SEED = 16'hACE1;
    localparam logic signed [EXT_W-1:0] HALF_STEP = EXT_W'(2 ** (STEP_SH - 1));
    localparam logic signed [EXT_W-1:0] RAW_MAX   = EXT_W'(LMAX);
    localparam logic signed [EXT_W-1:0] RAW_MIN   = EXT_W'(-LMAX);
    localparam logic signed [Q_W-1:0]   CODE_MAX  = Q_W'(LMAX);
    localparam logic signed [Q_W-1:0]   CODE_MIN  = Q_W'(-LMAX);

    generate
        if (ORDER < 1 || ORDER > 4) begin : g_bad_order
            $error("dsm_cifb_mod: ORDER must be within 1..4");
        end
        if (ACC_W < IN_W + 4) begin : g_bad_acc
            $error("dsm_cifb_mod: ACC_W must be at least IN_W+4");
        end
        if (DITH_W < 1 || DITH_W > 16) begin : g_bad_dith
            $error("dsm_cifb_mod: DITH_W must be within 1..16");
        end
    endgenerate

    // Clip a guard-bit sum into the signed ACC_W range.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [EXT_W-1:0] v);
        logic [EXT_W-ACC_W:0] top;
        top = v[EXT_W-1:ACC_W-1];
        if ((&top) || !(|top)) begin
            sat_acc = v[ACC_W-1:0];
        end else if (v[EXT_W-1]) begin
            sat_acc = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            sat_acc = {1'b0, {(ACC_W-1){1'b1}}};
        end
    endfunction

    // Limit the floored quantizer value to the legal code range -LMAX..+LMAX.
    function automatic logic signed [Q_W-1:0] clamp_code(input logic signed [EXT_W-1:0] raw);
        if (raw > RAW_MAX) begin
            clamp_code = CODE_MAX;
        end else if (raw < RAW_MIN) begin
            clamp_code = CODE_MIN;
        end else begin
            clamp_code = raw[Q_W-1:0];
        end
    endfunction

    // One shift of the Fibonacci LFSR for x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RECOVER} state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] x_q   [ORDER];
    logic signed [ACC_W-1:0] x_d   [ORDER];
    logic signed [ACC_W-1:0] x_upd [ORDER];
    logic [15:0]             lfsr_q, lfsr_d;
    logic [OVL_W-1:0]        ovl_cnt_q, ovl_cnt_d;
    logic [REC_W-1:0]        rec_cnt_q, rec_cnt_d;
    logic signed [Q_W-1:0]   code_q, code_d;
    logic                    vld_q, vld_d;
    logic                    flag_q, flag_d;

    logic signed [DITH_W-1:0] dith_raw;
    logic signed [EXT_W-1:0]  dith_ext;
    logic signed [EXT_W-1:0]  q_sum;
    logic signed [EXT_W-1:0]  q_raw;
    logic signed [EXT_W-1:0]  fb_ext;
    logic signed [Q_W-1:0]    code_next;
    logic                     clamped;
    logic                     accept;

    // The quantizer reads the last integrator. Adding half a step before the floor
    // makes it round to the nearest level, and the dither is added on top.
    assign dith_raw  = lfsr_q[15 -: DITH_W];
    assign dith_ext  = bus.dith_en ? EXT_W'(dith_raw) : '0;
    assign q_sum     = EXT_W'(x_q[ORDER-1]) + HALF_STEP + dith_ext;
    assign q_raw     = q_sum >>> STEP_SH;
    assign code_next = clamp_code(q_raw);
    assign clamped   = (q_raw != EXT_W'(code_next));
    assign fb_ext    = EXT_W'(code_next) <<< STEP_SH;
    assign accept    = bus.in_valid && ((state_q == S_RUN) || (state_q == S_RECOVER));

    // Integrator chain update from the pre-update registers, with every sum saturated.
    always_comb begin
        logic signed [EXT_W-1:0] diff;
        diff     = '0;
        x_upd[0] = sat_acc(EXT_W'(x_q[0]) + EXT_W'(bus.vin) - fb_ext);
        for (int k = 1; k < ORDER; k++) begin
            diff     = EXT_W'(x_q[k-1]) - fb_ext;
            x_upd[k] = sat_acc(EXT_W'(x_q[k]) + (diff >>> GAIN_SHIFT));
        end
    end

    // Next-state and output logic: IDLE / RUN / RECOVER with overload tracking.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        lfsr_d    = lfsr_q;
        ovl_cnt_d = ovl_cnt_q;
        rec_cnt_d = rec_cnt_q;
        code_d    = code_q;
        vld_d     = 1'b0;
        flag_d    = flag_q && !bus.ovl_clr;

        if (!bus.en) begin
            state_d   = S_IDLE;
            x_d       = '{default: '0};
            lfsr_d    = LFSR_SEED;
            ovl_cnt_d = '0;
            rec_cnt_d = '0;
            code_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_RUN;
                    x_d     = '{default: '0};
                    code_d  = '0;
                end
                S_RUN: begin
                    if (accept) begin
                        vld_d  = 1'b1;
                        code_d = code_next;
                        lfsr_d = lfsr_next(lfsr_q);
                        x_d    = x_upd;
                        if (clamped) begin
                            if (ovl_cnt_q == OVL_W'(OVL_LIMIT - 1)) begin
                                // This sample still sends its code. The loop state is flushed here.
                                state_d   = S_RECOVER;
                                flag_d    = 1'b1;
                                ovl_cnt_d = '0;
                                x_d       = '{default: '0};
                            end else begin
                                ovl_cnt_d = ovl_cnt_q + 1'b1;
                            end
                        end else begin
                            ovl_cnt_d = '0;
                        end
                    end
                end
                S_RECOVER: begin
                    x_d = '{default: '0};
                    if (accept) begin
                        vld_d  = 1'b1;
                        code_d = '0;
                        lfsr_d = lfsr_next(lfsr_q);
                        if (rec_cnt_q == REC_W'(RECOVER_LEN - 1)) begin
                            state_d   = S_RUN;
                            rec_cnt_d = '0;
                        end else begin
                            rec_cnt_d = rec_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register. Reset is synchronous and active-low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            x_q       <= '{default: '0};
            lfsr_q    <= LFSR_SEED;
            ovl_cnt_q <= '0;
            rec_cnt_q <= '0;
            code_q    <= '0;
            vld_q     <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            lfsr_q    <= lfsr_d;
            ovl_cnt_q <= ovl_cnt_d;
            rec_cnt_q <= rec_cnt_d;
            code_q    <= code_d;
            vld_q     <= vld_d;
            flag_q    <= flag_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out_code  = code_q;
    assign bus.ovl_flag  = flag_q;
endmodule

// File: doc/dsm_cifb_mod.md
Name: dsm_cifb_mod

Overview:
- Parametrised, multi-bit, configurable-order delta-sigma modulator with CIFB (cascade-of-integrators feedback) topology.
- Next generation of the fixed 4-tap ternary modulator. Adds:
  - sample-strobe handshake
  - selectable order and output level count
  - internal LFSR dither
  - integrator saturation
  - overload detection with automatic state recovery
- Sits between the input sample source and the power-stage PWM/level driver.

Parameters:
- IN_W, 11, input sample width (signed two's complement).
- ACC_W, 17, integrator width (signed); must be at least IN_W+4.
- ORDER, 2, number of integrators, 1..4.
- Q_W, 2, output code width (signed). LMAX = 2^(Q_W-1)-1. The default gives codes -1/0/+1.
- GAIN_SHIFT, 1, arithmetic right shift applied to the input of integrators 2..ORDER.
- DITH_W, 4, dither magnitude width in bits.
- OVL_LIMIT, 16, number of consecutive clamped samples that triggers recovery.
- RECOVER_LEN, 8, number of accepted samples spent in RECOVER.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-low reset.
- en, input, 1, modulator enable.
- dith_en, input, 1, enables dither addition at the quantizer.
- in_valid, input, 1, sample strobe for vin.
- vin, input, IN_W, signed input sample.
- out_valid, output, 1, one-cycle pulse marking a new out_code.
- out_code, output, Q_W, signed quantizer level, -LMAX..+LMAX.
- ovl_flag, output, 1, sticky overload indicator.
- ovl_clr, input, 1, clears ovl_flag.

Behaviour:
- One clock. reset is synchronous and active-low: reset==0 at a rising edge resets the block.
- Reset values:
  - state = IDLE
  - all integrators x1..xORDER = 0
  - out_code = 0, out_valid = 0, ovl_flag = 0
  - ovl_cnt = 0, rec_cnt = 0
  - LFSR = 16'hACE1
- Reset mid-operation discards all state; no out_valid is produced in that cycle.
- STEP = 2^(IN_W-2); feedback value fb = out_code_next*STEP, sign-extended to ACC_W.
- Accepted sample: in_valid==1 while state is RUN or RECOVER. Otherwise all state holds.
- Quantizer, evaluated on an accepted sample from the registered xORDER:
  - d = dith_en ? sign-extended LFSR[15:16-DITH_W] : 0.
  - raw = (xORDER + STEP/2 + d) >>> (IN_W-2), arithmetic, i.e. a floor.
  - out_code_next = clamp(raw, -LMAX, +LMAX).
  - clamped = (raw != out_code_next).
- Integrator update on an accepted sample in RUN. All right-hand sides use the pre-update registers; every sum is saturated to the ACC_W signed range, never wrapped.
  - x1 <= sat(x1 + sext(vin) - fb)
  - xk <= sat(xk + ((x(k-1) - fb) >>> GAIN_SHIFT)), for k = 2..ORDER
- The LFSR advances one step per accepted sample.
  - Polynomial x^16+x^14+x^13+x^11+1, Fibonacci form, shift left.
  - Feedback bit = b15^b13^b12^b10.
- Output latency:
  - out_code and out_valid are registered. out_valid goes high exactly one cycle after the accepting edge, for one cycle.
  - out_code holds its value between strobes.
  - Back-to-back in_valid gives out_valid on every cycle.
- FSM:
  - IDLE: out_code = 0, integrators = 0, out_valid = 0, in_valid ignored. en==1 -> RUN at the next edge.
  - RUN, on each accepted sample:
    - clamped==1 -> ovl_cnt++; otherwise ovl_cnt = 0.
    - When ovl_cnt would reach OVL_LIMIT: go to RECOVER, set ovl_flag = 1, clear ovl_cnt. That sample's code is still output normally.
  - RECOVER:
    - Integrators forced to 0. out_code = 0 with out_valid pulses still produced per accepted sample.
    - rec_cnt counts accepted samples. After RECOVER_LEN of them -> RUN with rec_cnt = 0.
  - en==0 in any state -> IDLE at the next edge. Integrators, counters and LFSR clear; ovl_flag is kept.
- ovl_flag:
  - Sticky; cleared by ovl_clr==1.
  - If a set event and ovl_clr occur in the same cycle, set wins.
- ORDER==1: GAIN_SHIFT is unused.
- Out-of-range parameters (ORDER outside 1..4, ACC_W < IN_W+4) are an elaboration error.

Test Plan:
- Reset/idle: reset=0 for 2 cycles, then en=0 with in_valid toggling -> out_valid stays 0, out_code=0, ovl_flag=0.
- Zero input: default parameters, dith_en=0, vin=0, 64 back-to-back strobes -> 64 out_valid pulses, each one cycle after its strobe, all out_code=0.
- DC tracking:
  - vin=+256, 256 strobes, dith_en=0 -> count of +1 codes in [126,130], no -1 codes.
  - vin=-256 -> mirror result.
  - ovl_flag stays 0.
- Strobe gaps: in_valid on every 3rd cycle with vin=+256 -> the code sequence equals the back-to-back sequence. Integrators and LFSR are unchanged on idle cycles, checked by probe.
- Overload: vin=+1000 (exceeds LMAX*STEP=512) -> ovl_flag=1 within 40 strobes, then exactly 8 strobes output code 0 with integrators 0, then RUN resumes. ovl_clr pulse -> ovl_flag=0 unless the same cycle sets it.
- Mid-run controls:
  - reset=0 mid-stream -> next edge shows all outputs at reset values, LFSR = 16'hACE1.
  - en drop then re-raise with dith_en=1 -> the first 16 dither values match the reference LFSR sequence from the seed.
